// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer and the HI/LO source muxes.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        M_START,
        M_RUN,
        D_START,
        D_RUN,
        WB,
        FIN,
        DZ
    } seqState_t;

    localparam logic SEL_MULT = 1'b0;
    localparam logic SEL_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_cycle_counter.sv
// Loadable down-counter that times the fixed latency of the multiply/divide units.
module muldiv_cycle_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    input  logic             decEn,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // Load wins over decrement; the count saturates at zero instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (decEn && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiply/divide units: start pulse, latency count, HI/LO write, done.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic req_mult,
    input  logic req_div,
    input  logic b_is_zero,
    input  logic flush,
    output logic mult_ctrl,
    output logic div_ctrl,
    output logic mult_div_sel,
    output logic hi_we,
    output logic lo_we,
    output logic busy,
    output logic done,
    output logic div0_excp
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    seqState_t        state;
    seqState_t        nextState;
    logic             selReg;
    logic             selNext;
    logic             cntLoad;
    logic [CNT_W-1:0] cntLoadValue;
    logic             cntDec;
    logic [CNT_W-1:0] cntValue;
    logic             cntZero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            selReg <= SEL_MULT;
        end else begin
            state  <= nextState;
            selReg <= selNext;
        end
    end

    // FIN dispatches like IDLE so a new request can start right after done.
    always_comb begin
        nextState = state;
        selNext   = selReg;
        unique case (state)
            IDLE, FIN: begin
                nextState = IDLE;
                if (!flush) begin
                    if (req_mult) begin
                        nextState = M_START;
                        selNext   = SEL_MULT;
                    end else if (req_div && b_is_zero) begin
                        nextState = DZ;
                    end else if (req_div) begin
                        nextState = D_START;
                        selNext   = SEL_DIV;
                    end
                end
            end
            M_START: nextState = M_RUN;
            M_RUN:   nextState = cntZero ? WB : M_RUN;
            D_START: nextState = D_RUN;
            D_RUN:   nextState = cntZero ? WB : D_RUN;
            WB:      nextState = FIN;
            DZ:      nextState = IDLE;
        endcase
        if (flush) begin
            nextState = IDLE;
        end
    end

    assign cntLoad      = (state == M_START) || (state == D_START);
    assign cntLoadValue = (state == D_START) ? DIV_LOAD : MULT_LOAD;
    assign cntDec       = ((state == M_RUN) || (state == D_RUN)) && (cntValue != '0);

    muldiv_cycle_counter #(
        .CNT_W(CNT_W)
    ) uCounter (
        .clk      (clk),
        .reset    (reset),
        .load     (cntLoad),
        .loadValue(cntLoadValue),
        .decEn    (cntDec),
        .count    (cntValue),
        .zero     (cntZero)
    );

    assign mult_ctrl    = (state == M_START);
    assign div_ctrl     = (state == D_START);
    assign hi_we        = (state == WB);
    assign lo_we        = (state == WB);
    assign done         = (state == FIN);
    assign div0_excp    = (state == DZ);
    assign busy         = (state != IDLE);
    assign mult_div_sel = selReg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: a timing model predicts output events per request.
module tb_muldiv_sequencer;

    localparam int MULT_CYCLES = 32;
    localparam int DIV_CYCLES  = 4;
    localparam int CNT_W       = 6;

    localparam int K_NONE = 0;
    localparam int K_MST  = 1;
    localparam int K_DST  = 2;
    localparam int K_WB   = 3;
    localparam int K_DONE = 4;
    localparam int K_DZ   = 5;
    localparam int K_BAD  = 6;

    typedef struct {
        int kind;
        int cyc;
    } expEvent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req_mult = 1'b0;
    logic req_div = 1'b0;
    logic b_is_zero = 1'b0;
    logic flush = 1'b0;
    logic mult_ctrl, div_ctrl, mult_div_sel, hi_we, lo_we, busy, done, div0_excp;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    expEvent_t expQ[$];
    int   acceptFrom = 0;
    int   busyStart = 0;
    int   busyEnd = -1;
    logic modelSel = 1'b0;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_mult    (req_mult),
        .req_div     (req_div),
        .b_is_zero   (b_is_zero),
        .flush       (flush),
        .mult_ctrl   (mult_ctrl),
        .div_ctrl    (div_ctrl),
        .mult_div_sel(mult_div_sel),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .busy        (busy),
        .done        (done),
        .div0_excp   (div0_excp)
    );

    function automatic logic [7:0] allOutputs();
        return {mult_ctrl, div_ctrl, mult_div_sel, hi_we, lo_we, busy, done, div0_excp};
    endfunction

    function automatic void pushEvent(int kind, int c);
        expEvent_t ev;
        ev.kind = kind;
        ev.cyc  = c;
        expQ.push_back(ev);
    endfunction

    // A unit op accepted at edge e: start in cycle e, write after the latency, done next.
    function automatic void startOp(int e, int kind, int latency, logic sel);
        pushEvent(kind, e);
        pushEvent(K_WB, e + latency + 1);
        pushEvent(K_DONE, e + latency + 2);
        busyStart  = e;
        busyEnd    = e + latency + 2;
        acceptFrom = e + latency + 3;
        modelSel   = sel;
    endfunction

    function automatic void modelEdge(int e);
        if (flush) begin
            while (expQ.size() > 0 && expQ[$].cyc >= e) begin
                void'(expQ.pop_back());
            end
            if (busyEnd >= e) busyEnd = e - 1;
            acceptFrom = e + 1;
        end else if (e >= acceptFrom && (req_mult || req_div)) begin
            if (req_mult) begin
                startOp(e, K_MST, MULT_CYCLES, 1'b0);
            end else if (b_is_zero) begin
                pushEvent(K_DZ, e);
                busyStart  = e;
                busyEnd    = e;
                acceptFrom = e + 2;
            end else begin
                startOp(e, K_DST, DIV_CYCLES, 1'b1);
            end
        end
    endfunction

    task automatic applyStimulus(input logic m, input logic d, input logic bz, input logic f);
        req_mult  = m;
        req_div   = d;
        b_is_zero = bz;
        flush     = f;
        modelEdge(cyc + 1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic waitReady();
        int guard = 0;
        while (cyc + 1 < acceptFrom && guard < 200) begin
            idle(1);
            guard++;
        end
    endtask

    task automatic applyReset(input int holdCycles);
        reset = 1'b0;
        expQ.delete();
        busyEnd    = -1;
        acceptFrom = 0;
        modelSel   = 1'b0;
        #1;
        checks++;
        if (allOutputs() !== 8'h00) begin
            errors++;
            $display("[TB] FAIL async reset at cycle %0d: got %b expected 00000000", cyc, allOutputs());
        end
        repeat (holdCycles) begin
            @(negedge clk);
            req_mult  = 1'($urandom_range(0, 1));
            req_div   = 1'($urandom_range(0, 1));
            b_is_zero = 1'($urandom_range(0, 1));
            flush     = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        req_mult  = 1'b0;
        req_div   = 1'b0;
        b_is_zero = 1'b0;
        flush     = 1'b0;
        reset     = 1'b1;
    endtask

    task automatic checkOutput();
        int   obsKind;
        int   expKind;
        int   active;
        bit   hasExp;
        logic expBusy;
        if (!reset) begin
            checks++;
            if (allOutputs() !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset outputs cycle %0d: got %b expected 00000000", cyc, allOutputs());
            end
            return;
        end
        expBusy = (cyc >= busyStart) && (cyc <= busyEnd);
        checks++;
        if (busy !== expBusy || mult_div_sel !== modelSel) begin
            errors++;
            $display("[TB] FAIL busy/sel cycle %0d: got busy=%b sel=%b expected busy=%b sel=%b",
                     cyc, busy, mult_div_sel, expBusy, modelSel);
        end
        active = int'(mult_ctrl) + int'(div_ctrl) + int'(hi_we | lo_we) + int'(done) + int'(div0_excp);
        if (hi_we !== lo_we || active > 1) obsKind = K_BAD;
        else if (mult_ctrl) obsKind = K_MST;
        else if (div_ctrl)  obsKind = K_DST;
        else if (hi_we)     obsKind = K_WB;
        else if (done)      obsKind = K_DONE;
        else if (div0_excp) obsKind = K_DZ;
        else                obsKind = K_NONE;
        hasExp  = (expQ.size() > 0) && (expQ[0].cyc == cyc);
        expKind = hasExp ? expQ[0].kind : K_NONE;
        if (obsKind != K_NONE || hasExp) begin
            checks++;
            if (hasExp) void'(expQ.pop_front());
            if (obsKind != expKind) begin
                errors++;
                $display("[TB] FAIL event cycle %0d: got kind %0d expected kind %0d (1=mstart 2=dstart 3=wb 4=done 5=div0 6=illegal)",
                         cyc, obsKind, expKind);
            end
        end
    endtask

    // Monitor: count edges and compare the DUT against the scoreboard 1 ns after each edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            checkOutput();
        end
    end

    initial begin
        @(negedge clk);
        applyReset(4);
        idle(5);

        waitReady();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(40);

        waitReady();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(6);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(10);

        waitReady();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);

        waitReady();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        idle(10);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(40);

        waitReady();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(9);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        idle(40);

        waitReady();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(MULT_CYCLES + 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        idle(10);

        waitReady();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);
        applyReset(2);
        idle(5);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                applyReset(2);
            end else begin
                applyStimulus(1'($urandom_range(0, 9) == 0),
                              1'($urandom_range(0, 6) == 0),
                              1'($urandom_range(0, 3) == 0),
                              1'($urandom_range(0, 29) == 0));
            end
        end
        idle(MULT_CYCLES + 10);

        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL leftover events: got %0d pending expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
